// File: rtl/pet_vid_pkg.sv
// pet_vid_pkg
// Shared geometry defaults, derived constants, the column-mode enum and a
// counter-width helper for the PET video timing chain.
package pet_vid_pkg;

  // Default 40/80-column PET geometry
  localparam int unsigned H_DISP_DEF    = 32'd40;
  localparam int unsigned H_TOTAL_DEF   = 32'd64;
  localparam int unsigned H_SYNC_ST_DEF = 32'd48;
  localparam int unsigned H_SYNC_W_DEF  = 32'd4;
  localparam int unsigned SCAN_ROW_DEF  = 32'd8;
  localparam int unsigned V_ROWS_DEF    = 32'd25;
  localparam int unsigned V_TOTAL_DEF   = 32'd260;
  localparam int unsigned V_SYNC_ST_DEF = 32'd224;
  localparam int unsigned V_SYNC_W_DEF  = 32'd4;
  localparam int unsigned ADDR_W_DEF    = 32'd11;

  // Width of a counter holding 0..n-1 (never narrower than one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  // Derived defaults: scanlines covered by the text area and scan index width
  localparam int unsigned ROW_LINES_DEF = V_ROWS_DEF * SCAN_ROW_DEF;
  localparam int unsigned SCAN_W_DEF    = cnt_width(SCAN_ROW_DEF);

  // Column mode latched once per frame
  typedef enum logic {
    MODE_40 = 1'b0,
    MODE_80 = 1'b1
  } vid_mode_e;

endpackage

// File: rtl/pet_vid_cnt.sv
// pet_vid_cnt
// Generic modulo-N counter with enable, synchronous clear and a wrap pulse.
// Ports:
//   i_clk      system clock
//   i_reset_n  synchronous active-low reset
//   i_en       advance enable
//   i_clr      force the next enabled step to 0 (only acts with i_en)
//   o_cnt      current count 0..N-1
//   o_wrap     combinational: enabled step at N-1 (count returns to 0)
module pet_vid_cnt #(
  parameter int unsigned N = 32'd8,
  parameter int unsigned W = 32'd3
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;
  logic         w_at_top;

  assign w_at_top = (r_cnt == W'(N - 32'd1));
  assign o_wrap   = i_en && w_at_top;
  assign o_cnt    = r_cnt;

  // Count register: advance on enable, return to 0 at the top or on clear
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_clr || w_at_top) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + W'(1'b1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/pet_vid_timing.sv
// pet_vid_timing
// Character-cell video timing for the PET display: video RAM address,
// scanline within the character row, display enable, sync and retrace.
// The counters always point at the NEXT cell to be shown. Each ce_char
// strobe registers the outputs for the cell the counters point at and then
// advances them, so the first strobe after reset presents cell (0,0).
// Ports:
//   i_clk        system clock
//   i_reset_n    synchronous active-low reset
//   i_ce_char    one-clk strobe per character time
//   i_col80      column mode request (1 = 80 columns), taken at frame start
//   i_blank_req  external blanking, gates disp_en with one clk latency
//   o_vaddr      video RAM address (even cell of the pair in 80-col mode)
//   o_scan       scanline within the character row
//   o_disp_en    active display and not blanked
//   o_hsync      horizontal drive, active high
//   o_vsync      vertical drive, active high
//   o_vretrace   scanline lies below the text area
//   o_sof        one-clk pulse on the first cell of a frame
module pet_vid_timing
  import pet_vid_pkg::*;
#(
  parameter int unsigned H_DISP    = H_DISP_DEF,
  parameter int unsigned H_TOTAL   = H_TOTAL_DEF,
  parameter int unsigned H_SYNC_ST = H_SYNC_ST_DEF,
  parameter int unsigned H_SYNC_W  = H_SYNC_W_DEF,
  parameter int unsigned SCAN_ROW  = SCAN_ROW_DEF,
  parameter int unsigned V_ROWS    = V_ROWS_DEF,
  parameter int unsigned V_TOTAL   = V_TOTAL_DEF,
  parameter int unsigned V_SYNC_ST = V_SYNC_ST_DEF,
  parameter int unsigned V_SYNC_W  = V_SYNC_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_ce_char,
  input  logic                             i_col80,
  input  logic                             i_blank_req,
  output logic [ADDR_W-1:0]                o_vaddr,
  output logic [cnt_width(SCAN_ROW)-1:0]   o_scan,
  output logic                             o_disp_en,
  output logic                             o_hsync,
  output logic                             o_vsync,
  output logic                             o_vretrace,
  output logic                             o_sof
);

  localparam int unsigned HCNT_W    = cnt_width(H_TOTAL);
  localparam int unsigned VCNT_W    = cnt_width(V_TOTAL);
  localparam int unsigned SCAN_W    = cnt_width(SCAN_ROW);
  localparam int unsigned ROW_LINES = V_ROWS * SCAN_ROW;

  // Counter chain
  logic [HCNT_W-1:0] w_hcnt;
  logic [VCNT_W-1:0] w_vcnt;
  logic [SCAN_W-1:0] w_scan;
  logic              w_h_wrap;
  logic              w_v_wrap;
  logic              w_scan_wrap;

  // Decode of the cell the counters point at
  logic [31:0]       w_h32;
  logic [31:0]       w_v32;
  logic              w_frame_start;
  logic              w_active;
  logic              w_active_sel;
  logic              w_hsync;
  logic              w_vsync;
  logic              w_vretrace;
  logic [ADDR_W-1:0] w_hcnt_ext;
  logic [ADDR_W-1:0] w_hoff;
  logic [ADDR_W-1:0] w_stride;
  logic [ADDR_W-1:0] w_vaddr;

  // State and output registers
  vid_mode_e         r_mode;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_vaddr;
  logic [SCAN_W-1:0] r_scan;
  logic              r_active;
  logic              r_disp_en;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_vretrace;
  logic              r_sof;

  pet_vid_cnt #(.N(H_TOTAL), .W(HCNT_W)) u_hcnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (i_ce_char),
    .i_clr     (1'b0),
    .o_cnt     (w_hcnt),
    .o_wrap    (w_h_wrap)
  );

  // Scan restarts at frame wrap even mid-row, since V_TOTAL need not be a
  // whole number of character rows.
  pet_vid_cnt #(.N(SCAN_ROW), .W(SCAN_W)) u_scan (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (w_h_wrap),
    .i_clr     (w_v_wrap),
    .o_cnt     (w_scan),
    .o_wrap    (w_scan_wrap)
  );

  pet_vid_cnt #(.N(V_TOTAL), .W(VCNT_W)) u_vcnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (w_h_wrap),
    .i_clr     (1'b0),
    .o_cnt     (w_vcnt),
    .o_wrap    (w_v_wrap)
  );

  assign w_h32 = 32'(w_hcnt);
  assign w_v32 = 32'(w_vcnt);

  // Strobe presenting cell (0,0): either a frame wrap or the first strobe
  // after reset. The mode is taken here so it applies to the whole frame.
  assign w_frame_start = i_ce_char && (w_hcnt == '0) && (w_vcnt == '0);

  assign w_active   = (w_h32 < H_DISP) && (w_v32 < ROW_LINES);
  assign w_hsync    = (w_h32 >= H_SYNC_ST) && (w_h32 < (H_SYNC_ST + H_SYNC_W));
  assign w_vsync    = (w_v32 >= V_SYNC_ST) && (w_v32 < (V_SYNC_ST + V_SYNC_W));
  assign w_vretrace = (w_v32 >= ROW_LINES);

  // In 80-column mode each char time fetches a cell pair, so the offset and
  // row stride double. All address arithmetic wraps modulo 2^ADDR_W.
  assign w_hcnt_ext = ADDR_W'(w_hcnt);
  assign w_hoff     = (r_mode == MODE_80) ? {w_hcnt_ext[ADDR_W-2:0], 1'b0} : w_hcnt_ext;
  assign w_stride   = (r_mode == MODE_80) ? ADDR_W'(32'd2 * H_DISP) : ADDR_W'(H_DISP);
  assign w_vaddr    = r_row_base + w_hoff;

  // Active-area flag feeding disp_en: fresh decode on a strobe, held otherwise
  always_comb begin
    w_active_sel = r_active;
    if (i_ce_char) begin
      w_active_sel = w_active;
    end else begin
      w_active_sel = r_active;
    end
  end

  // Column mode latch, updated only at frame start
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_mode <= MODE_40;
    end else if (w_frame_start) begin
      r_mode <= i_col80 ? MODE_80 : MODE_40;
    end else begin
      r_mode <= r_mode;
    end
  end

  // Row base address: clears at frame wrap, steps by one row stride per char row
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_row_base <= '0;
    end else if (w_v_wrap) begin
      r_row_base <= '0;
    end else if (w_scan_wrap) begin
      r_row_base <= r_row_base + w_stride;
    end else begin
      r_row_base <= r_row_base;
    end
  end

  // Output registers: cell outputs load on the strobe and hold between strobes;
  // sof is a single-clk pulse and disp_en tracks blank_req every clk
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_vaddr    <= '0;
      r_scan     <= '0;
      r_active   <= 1'b0;
      r_hsync    <= 1'b0;
      r_vsync    <= 1'b0;
      r_vretrace <= 1'b0;
      r_sof      <= 1'b0;
      r_disp_en  <= 1'b0;
    end else begin
      if (i_ce_char) begin
        r_vaddr    <= w_vaddr;
        r_scan     <= w_scan;
        r_active   <= w_active;
        r_hsync    <= w_hsync;
        r_vsync    <= w_vsync;
        r_vretrace <= w_vretrace;
      end else begin
        r_vaddr    <= r_vaddr;
        r_scan     <= r_scan;
        r_active   <= r_active;
        r_hsync    <= r_hsync;
        r_vsync    <= r_vsync;
        r_vretrace <= r_vretrace;
      end
      r_sof     <= w_frame_start;
      r_disp_en <= w_active_sel && !i_blank_req;
    end
  end

  assign o_vaddr    = r_vaddr;
  assign o_scan     = r_scan;
  assign o_disp_en  = r_disp_en;
  assign o_hsync    = r_hsync;
  assign o_vsync    = r_vsync;
  assign o_vretrace = r_vretrace;
  assign o_sof      = r_sof;

endmodule

// File: tb/tb_pet_vid_timing.sv
// tb_pet_vid_timing
// Self-checking bench for pet_vid_timing: a short table of fixed vectors,
// directed sequences for the frame/row/mode/reset corner cases, and a random
// phase, all compared each clk against a frame-position reference model.
module tb_pet_vid_timing;

  localparam int H_DISP    = 40;
  localparam int H_TOTAL   = 64;
  localparam int SCAN_ROW  = 8;
  localparam int V_ROWS    = 25;
  localparam int V_TOTAL   = 260;
  localparam int FRAME     = H_TOTAL * V_TOTAL;

  logic        clk = 1'b0;
  logic        i_reset_n, i_ce_char, i_col80, i_blank_req;
  logic [10:0] o_vaddr;
  logic [2:0]  o_scan;
  logic        o_disp_en, o_hsync, o_vsync, o_vretrace, o_sof;

  always #5 clk = ~clk;

  pet_vid_timing dut (
    .i_clk       (clk),
    .i_reset_n   (i_reset_n),
    .i_ce_char   (i_ce_char),
    .i_col80     (i_col80),
    .i_blank_req (i_blank_req),
    .o_vaddr     (o_vaddr),
    .o_scan      (o_scan),
    .o_disp_en   (o_disp_en),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync),
    .o_vretrace  (o_vretrace),
    .o_sof       (o_sof)
  );

  typedef struct {
    logic        rst_n, ce, c80, blank;
    logic [10:0] vaddr;
    logic [2:0]  scan;
    logic        disp, hs, vr, sof;
  } vec_t;

  vec_t tbl [8];

  // Reference model: position within the frame of the next cell to show
  int          m_p;
  bit          m_mode, m_active;
  logic [10:0] e_vaddr;
  logic [2:0]  e_scan;
  logic        e_disp, e_hs, e_vs, e_vr, e_sof;

  int vectors = 0;
  int miscompares = 0;
  int idx = -1;
  int hs_cnt, de_cnt, vs_cnt, sof_cnt, vr_first, vs_first;
  bit g_c80 = 1'b0;
  bit g_blank = 1'b0;

  task automatic clear_stats();
    hs_cnt = 0; de_cnt = 0; vs_cnt = 0; sof_cnt = 0; vr_first = -1; vs_first = -1;
  endtask

  task automatic model_update(input bit rst, input bit ce, input bit c80, input bit bl);
    int h, v, stride;
    if (!rst) begin
      m_p = 0; m_mode = 1'b0; m_active = 1'b0; idx = -1;
      e_vaddr = '0; e_scan = '0; e_disp = 1'b0; e_hs = 1'b0;
      e_vs = 1'b0; e_vr = 1'b0; e_sof = 1'b0;
    end else begin
      if (ce) begin
        h = m_p % H_TOTAL;
        v = m_p / H_TOTAL;
        if (m_p == 0) m_mode = c80;
        stride   = m_mode ? 2 * H_DISP : H_DISP;
        e_vaddr  = 11'(((v / SCAN_ROW) * stride + h * (m_mode ? 2 : 1)) % 2048);
        e_scan   = 3'(v % SCAN_ROW);
        m_active = (h < H_DISP) && (v < V_ROWS * SCAN_ROW);
        e_hs     = (h >= 48) && (h < 52);
        e_vs     = (v >= 224) && (v < 228);
        e_vr     = (v >= V_ROWS * SCAN_ROW);
        e_sof    = (m_p == 0);
        m_p      = (m_p + 1) % FRAME;
        idx      = idx + 1;
      end else begin
        e_sof = 1'b0;
      end
      e_disp = m_active && !bl;
    end
  endtask

  task automatic apply(input bit rst, input bit ce, input bit c80, input bit bl);
    i_reset_n = rst; i_ce_char = ce; i_col80 = c80; i_blank_req = bl;
    @(posedge clk);
    model_update(rst, ce, c80, bl);
    @(negedge clk);
    vectors = vectors + 1;
    if (o_vaddr !== e_vaddr || o_scan !== e_scan || o_disp_en !== e_disp ||
        o_hsync !== e_hs || o_vsync !== e_vs || o_vretrace !== e_vr || o_sof !== e_sof) begin
      miscompares = miscompares + 1;
      $display("FAIL model idx=%0d got vaddr=%0d scan=%0d de=%b hs=%b vs=%b vr=%b sof=%b want vaddr=%0d scan=%0d de=%b hs=%b vs=%b vr=%b sof=%b",
               idx, o_vaddr, o_scan, o_disp_en, o_hsync, o_vsync, o_vretrace, o_sof,
               e_vaddr, e_scan, e_disp, e_hs, e_vs, e_vr, e_sof);
    end
    if (rst && ce) begin
      if (o_hsync) hs_cnt = hs_cnt + 1;
      if (o_disp_en) de_cnt = de_cnt + 1;
      if (o_sof) sof_cnt = sof_cnt + 1;
      if (o_vretrace && vr_first < 0) vr_first = idx;
      if (o_vsync) begin
        vs_cnt = vs_cnt + 1;
        if (vs_first < 0) vs_first = idx;
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    vectors = vectors + 1;
    if (got != want) begin
      miscompares = miscompares + 1;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Strobe continuously until the presented cell index reaches target
  task automatic run_to(input int target);
    while (idx < target) apply(1'b1, 1'b1, g_c80, g_blank);
  endtask

  task automatic do_reset();
    apply(1'b0, 1'b0, g_c80, 1'b0);
    clear_stats();
  endtask

  initial begin
    bit r, c, b;
    i_reset_n = 1'b0; i_ce_char = 1'b0; i_col80 = 1'b0; i_blank_req = 1'b0;

    //            rst  ce   c80  blank vaddr  scan  disp hs   vr   sof
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 11'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 11'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 11'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 11'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 11'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].rst_n, tbl[i].ce, tbl[i].c80, tbl[i].blank);
      vectors = vectors + 1;
      if (o_vaddr !== tbl[i].vaddr || o_scan !== tbl[i].scan || o_disp_en !== tbl[i].disp ||
          o_hsync !== tbl[i].hs || o_vretrace !== tbl[i].vr || o_sof !== tbl[i].sof) begin
        miscompares = miscompares + 1;
        $display("FAIL table[%0d] got vaddr=%0d scan=%0d de=%b hs=%b vr=%b sof=%b want vaddr=%0d scan=%0d de=%b hs=%b vr=%b sof=%b",
                 i, o_vaddr, o_scan, o_disp_en, o_hsync, o_vretrace, o_sof,
                 tbl[i].vaddr, tbl[i].scan, tbl[i].disp, tbl[i].hs, tbl[i].vr, tbl[i].sof);
      end
    end

    // 40-column full frame
    g_c80 = 1'b0; g_blank = 1'b0;
    do_reset();
    run_to(39);
    chk("line0_last_vaddr", int'(o_vaddr), 39);
    run_to(63);
    chk("line0_hsync_cells", hs_cnt, 4);
    chk("line0_disp_cells", de_cnt, 40);
    run_to(8 * 64);
    chk("row1_vaddr", int'(o_vaddr), 40);
    chk("row1_scan", int'(o_scan), 0);
    run_to(192 * 64);
    chk("row24_vaddr40", int'(o_vaddr), 960);
    run_to(FRAME);
    chk("vretrace_first", vr_first, 200 * 64);
    chk("vsync_first", vs_first, 224 * 64);
    chk("vsync_cells", vs_cnt, 4 * 64);
    chk("sof_count", sof_cnt, 2);
    chk("frame2_vaddr", int'(o_vaddr), 0);
    chk("frame2_sof", int'(o_sof), 1);

    // 80-column from reset
    g_c80 = 1'b1;
    do_reset();
    run_to(39);
    chk("c80_line0_last", int'(o_vaddr), 78);
    run_to(8 * 64);
    chk("c80_row1_vaddr", int'(o_vaddr), 80);
    run_to(192 * 64);
    chk("c80_row24_vaddr", int'(o_vaddr), 1920);

    // Mode toggled mid-frame takes effect only after the frame wraps
    g_c80 = 1'b0;
    do_reset();
    run_to(100 * 64 - 1);
    g_c80 = 1'b1;
    run_to(101 * 64 + 5);
    chk("toggle_same_frame", int'(o_vaddr), 485);
    run_to(FRAME + 8 * 64 + 3);
    chk("toggle_next_frame", int'(o_vaddr), 86);

    // Reset mid-frame, then reset with ce_char stuck high
    g_c80 = 1'b0;
    do_reset();
    run_to(150 * 64 + 7);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_outs", int'({o_vaddr, o_scan, o_disp_en, o_hsync, o_vsync, o_vretrace, o_sof}), 0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_next", int'({o_vaddr, o_scan, o_disp_en}), 1);
    run_to(40);
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_ce_outs", int'({o_vaddr, o_scan, o_disp_en, o_hsync, o_vsync, o_vretrace, o_sof}), 0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_ce_next", int'({o_vaddr, o_scan, o_disp_en}), 1);

    // Blanking mid-line
    do_reset();
    run_to(9);
    g_blank = 1'b1;
    run_to(10);
    chk("blank_vaddr", int'(o_vaddr), 10);
    chk("blank_disp", int'(o_disp_en), 0);
    run_to(11);
    chk("blank_vaddr2", int'(o_vaddr), 11);
    g_blank = 1'b0;
    run_to(12);
    chk("unblank_disp", int'(o_disp_en), 1);

    // Random stimulus against the model
    do_reset();
    for (int n = 0; n < 20000; n++) begin
      r = ($urandom_range(0, 24999) != 0);
      c = ($urandom_range(0, 7) != 0);
      b = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) g_c80 = !g_c80;
      apply(r, c, g_c80, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pet_vid_timing.md
Name: pet_vid_timing

Overview:
- Synthesizable, parametrised successor to the discrete PET video counter chain (horizontal char counter, scanline counter, row address latch, display-on, horizontal/vertical drive).
- Generates character-cell timing, the video RAM address, the scanline index within a character, the display enable and the sync/retrace strobes.
- Supports 40- or 80-column modes, selectable at runtime, and configurable screen geometry.
- Sits between the system clock-enable generator and the video RAM / character ROM / pixel shifter.

Parameters:
- H_DISP, 40: displayed character cells per line in 40-column mode.
- H_TOTAL, 64: total char times per line, including retrace.
- H_SYNC_ST, 48: char index where hsync asserts.
- H_SYNC_W, 4: hsync width in char times.
- SCAN_ROW, 8: scanlines per character row.
- V_ROWS, 25: displayed character rows.
- V_TOTAL, 260: total scanlines per frame.
- V_SYNC_ST, 224: scanline where vsync asserts.
- V_SYNC_W, 4: vsync width in scanlines.
- ADDR_W, 11: video address width; must satisfy 2^ADDR_W >= 2*H_DISP*V_ROWS.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- ce_char  in  1  one-clk strobe per character time; all counters advance only on it
- col80  in  1  mode select, 1 = 80 columns
- blank_req  in  1  external blanking request (PIA video off)
- vaddr  out  ADDR_W  video RAM address of current cell (even cell in 80-column mode)
- scan  out  $clog2(SCAN_ROW)  scanline within character row
- disp_en  out  1  cell is in active display and not blanked
- hsync  out  1  horizontal drive, active high
- vsync  out  1  vertical drive, active high
- vretrace  out  1  high from the first non-display scanline to the end of the frame (PET video_on / retrace interrupt source)
- sof  out  1  one-clk pulse on the first cell of each frame

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Clears hcnt, vcnt, scan, row_base and the latched mode.
  - Outputs: vaddr=0, scan=0, disp_en=0, hsync=0, vsync=0, vretrace=0, sof=0.
  - Applies mid-frame without glitch: the next ce_char after reset release is cell (0,0).
- Horizontal counter hcnt (0..H_TOTAL-1) increments on ce_char and wraps to 0. The wrap produces an end-of-line event.
- End-of-line:
  - vcnt increments; wraps at V_TOTAL-1 to 0.
  - scan increments; wraps at SCAN_ROW-1 to 0.
  - When scan wraps, row_base += stride, where stride = H_DISP in 40-column mode and 2*H_DISP in 80-column mode.
  - At vcnt wrap, row_base and scan clear regardless of scan phase.
- Mode latch: col80 is sampled into mode_q only at the frame wrap (vcnt and hcnt both wrapping). Mid-frame changes have no effect until the next frame.
- Address:
  - 40-column mode: vaddr = row_base + hcnt.
  - 80-column mode: vaddr = row_base + 2*hcnt; the pixel path fetches the pair vaddr and vaddr+1.
  - Arithmetic is modulo 2^ADDR_W with no saturation.
- Display enable: disp_en = (hcnt < H_DISP) && (vcnt < V_ROWS*SCAN_ROW) && !blank_req.
- Sync outputs:
  - hsync is high for H_SYNC_ST <= hcnt < H_SYNC_ST+H_SYNC_W.
  - vsync is high for V_SYNC_ST <= vcnt < V_SYNC_ST+V_SYNC_W.
  - vretrace = (vcnt >= V_ROWS*SCAN_ROW).
- sof is high for exactly one clk, the clk following the ce_char that wraps to (0,0).
- Latency and timing:
  - All outputs are registered and reflect the counter state updated by the most recent ce_char, one clk after that strobe.
  - Outputs hold between strobes.
  - ce_char held high continuously advances one cell per clk (legal).
- blank_req acts combinationally into the disp_en register (one-clk latency) and does not stop the counters.

Decomposition:
- Shared package pet_vid_pkg holds:
  - the default 40/80-column geometry constants;
  - the localparams for ROW_LINES = V_ROWS*SCAN_ROW and the scan width;
  - a mode enum (MODE_40, MODE_80).
- One natural sub-module: pet_vid_cnt, a generic modulo-N counter with enable and a wrap pulse. It is instantiated for hcnt, scan and vcnt.
- Address, sync compare and output registers stay in the top level.

Test Plan:
- Reset then 64 ce_char strobes, defaults, 40-column mode:
  - vaddr runs 0..39 with disp_en=1.
  - disp_en=0 for hcnt 40..63.
  - hsync is high exactly at hcnt 48..51.
- End of first character row, 40-column mode: after 8 lines, line 8 starts with vaddr=40 and scan=0.
- Start of last row, 40-column mode: line 192 starts with vaddr=960.
- 80-column mode from reset:
  - The first line gives vaddr 0,2,..,78.
  - Line 8 starts at vaddr=80.
  - Row 24 starts at vaddr=1920.
- Full frame (260*64 strobes):
  - vretrace rises at scanline 200.
  - vsync is high for scanlines 224..227.
  - sof pulses once per frame; the next frame begins at vaddr=0.
- Toggle col80 at scanline 100: addresses remain in 40-column stride until the frame wraps, then the 80-column stride applies.
- reset_n low for 1 clk at scanline 150 and again with ce_char stuck high: all outputs read 0, and the next strobe yields vaddr=0, scan=0, disp_en=1.
- Setting blank_req=1 mid-line forces disp_en=0 while vaddr keeps incrementing.
